// File: rtl/adder_pkg.sv
// Shared types and the generate/propagate combine operator for the
// carry-lookahead adder datapath.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_GROUP = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Associative lookahead operator: hi spans the more significant bits
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_group.sv
// One GROUP-bit lookahead group: group G/P, per-bit sums and the carry
// entering the group's most significant bit.
module cla_group
  import adder_pkg::*;
#(
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b_eff,
  input  logic             cin,
  output logic             grp_g,
  output logic             grp_p,
  output logic [GROUP-1:0] sum,
  output logic             c_msb
);

  logic [GROUP-1:0] g_s;
  logic [GROUP-1:0] p_s;
  logic [GROUP-1:0] c_s;
  logic             prop_s;
  gp_t              grp_s;

  assign g_s = a & b_eff;
  assign p_s = a ^ b_eff;

  // Bit carries as flat sum-of-products, no ripple through c_s
  always_comb begin
    c_s    = '0;
    prop_s = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      prop_s = 1'b1;
      c_s[i] = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        c_s[i] = c_s[i] | (prop_s & g_s[j]);
        prop_s = prop_s & p_s[j];
      end
      c_s[i] = c_s[i] | (prop_s & cin);
    end
  end

  // Group generate/propagate folded from the bit terms
  always_comb begin
    grp_s = '{g: g_s[0], p: p_s[0]};
    for (int i = 1; i < GROUP; i++) begin
      grp_s = gp_combine('{g: g_s[i], p: p_s[i]}, grp_s);
    end
  end

  assign sum   = p_s ^ c_s;
  assign c_msb = c_s[GROUP-1];
  assign grp_g = grp_s.g;
  assign grp_p = grp_s.p;

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on
// both sides and word-level G/P export for external cascading.
module cla_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             G_o,
  output logic             P_o
);

  localparam int NG = WIDTH / GROUP;

  if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("cla_adder_pipe: WIDTH must be a positive multiple of GROUP");
  end

  logic             s1_en_s;
  logic             s2_en_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;
  logic [WIDTH-1:0] g_in_s;
  logic [WIDTH-1:0] p_in_s;
  logic [NG-1:0]    gg_in_s;
  logic [NG-1:0]    gp_in_s;
  gp_t              grp_acc_s;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_g_r;
  logic [WIDTH-1:0] s1_p_r;
  logic [NG-1:0]    s1_gg_r;
  logic [NG-1:0]    s1_gp_r;
  logic             s1_cin_r;

  logic [NG:0]      c_s;
  logic             c_prop_s;
  logic [WIDTH-1:0] sum_s;
  logic [NG-1:0]    grp_g_s;
  logic [NG-1:0]    grp_p_s;
  logic [NG-1:0]    cmsb_s;
  gp_t              word_s;
  logic             unused_cmsb_s;

  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_sum_r;
  logic             s2_carry_r;
  logic             s2_ovf_r;
  logic             s2_g_r;
  logic             s2_p_r;

  assign s2_en_s = !s2_valid_r | ready_i;
  assign s1_en_s = !s1_valid_r | s2_en_s;
  assign ready_o = s1_en_s;

  assign b_eff_s   = b_i ^ {WIDTH{sub_i}};
  assign cin_eff_s = sub_i ? 1'b1 : carry_i;
  assign g_in_s    = a_i & b_eff_s;
  assign p_in_s    = a_i ^ b_eff_s;

  // Stage-1 group G/P using the same combine operator as cla_group
  always_comb begin
    gg_in_s   = '0;
    gp_in_s   = '0;
    grp_acc_s = '{g: 1'b0, p: 1'b1};
    for (int k = 0; k < NG; k++) begin
      grp_acc_s = '{g: g_in_s[k*GROUP], p: p_in_s[k*GROUP]};
      for (int i = 1; i < GROUP; i++) begin
        grp_acc_s = gp_combine('{g: g_in_s[k*GROUP+i], p: p_in_s[k*GROUP+i]}, grp_acc_s);
      end
      gg_in_s[k] = grp_acc_s.g;
      gp_in_s[k] = grp_acc_s.p;
    end
  end

  // Stage-1 register: valid flag and lookahead terms, loaded on s1_en
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_r <= 1'b0;
      s1_g_r     <= '0;
      s1_p_r     <= '0;
      s1_gg_r    <= '0;
      s1_gp_r    <= '0;
      s1_cin_r   <= 1'b0;
    end else if (s1_en_s) begin
      s1_valid_r <= valid_i;
      s1_g_r     <= g_in_s;
      s1_p_r     <= p_in_s;
      s1_gg_r    <= gg_in_s;
      s1_gp_r    <= gp_in_s;
      s1_cin_r   <= cin_eff_s;
    end
  end

  // Group carries as a flattened lookahead over the registered group terms
  always_comb begin
    c_s      = '0;
    c_prop_s = 1'b1;
    for (int k = 0; k <= NG; k++) begin
      c_prop_s = 1'b1;
      c_s[k]   = 1'b0;
      for (int j = k - 1; j >= 0; j--) begin
        c_s[k]   = c_s[k] | (c_prop_s & s1_gg_r[j]);
        c_prop_s = c_prop_s & s1_gp_r[j];
      end
      c_s[k] = c_s[k] | (c_prop_s & s1_cin_r);
    end
  end

  // g and p are disjoint, so a=g|p, b=g reproduces the original bit terms
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a     (s1_g_r[k*GROUP +: GROUP] | s1_p_r[k*GROUP +: GROUP]),
      .b_eff (s1_g_r[k*GROUP +: GROUP]),
      .cin   (c_s[k]),
      .grp_g (grp_g_s[k]),
      .grp_p (grp_p_s[k]),
      .sum   (sum_s[k*GROUP +: GROUP]),
      .c_msb (cmsb_s[k])
    );
  end

  assign unused_cmsb_s = ^cmsb_s;

  // Word G/P from the group terms, independent of the carry-in
  always_comb begin
    word_s = '{g: grp_g_s[0], p: grp_p_s[0]};
    for (int k = 1; k < NG; k++) begin
      word_s = gp_combine('{g: grp_g_s[k], p: grp_p_s[k]}, word_s);
    end
  end

  // Stage-2 register drives the outputs directly
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_r <= 1'b0;
      s2_sum_r   <= '0;
      s2_carry_r <= 1'b0;
      s2_ovf_r   <= 1'b0;
      s2_g_r     <= 1'b0;
      s2_p_r     <= 1'b0;
    end else if (s2_en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_sum_r   <= sum_s;
      s2_carry_r <= c_s[NG];
      s2_ovf_r   <= cmsb_s[NG-1] ^ c_s[NG];
      s2_g_r     <= word_s.g;
      s2_p_r     <= word_s.p;
    end
  end

  assign valid_o    = s2_valid_r;
  assign sum_o      = s2_sum_r;
  assign carry_o    = s2_carry_r;
  assign overflow_o = s2_ovf_r;
  assign G_o        = s2_g_r;
  assign P_o        = s2_p_r;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed and randomised checks of cla_adder_pipe against an arithmetic
// reference model and a FIFO scoreboard.
module tb_cla_adder_pipe;

  localparam int W   = 32;
  localparam int GRP = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         ov;
    logic         g;
    logic         p;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         carry_i;
  logic         sub_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;
  logic         overflow_o;
  logic         g_o;
  logic         p_o;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  bit   hold_v = 1'b0;
  res_t held_r;

  cla_adder_pipe #(.WIDTH(W), .GROUP(GRP)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .carry_i    (carry_i),
    .sub_i      (sub_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
    .overflow_o (overflow_o),
    .G_o        (g_o),
    .P_o        (p_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic [W:0]   nocin;
    res_t         r;
    be    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    nocin = {1'b0, a} + {1'b0, be};
    r.sum = full[W-1:0];
    r.c   = full[W];
    r.ov  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
    r.g   = nocin[W];
    r.p   = &(a ^ be);
    return r;
  endfunction

  function automatic res_t dut_res();
    return {sum_o, carry_o, overflow_o, g_o, p_o};
  endfunction

  task automatic chk(input string nm, input logic [W+3:0] act, input logic [W+3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    a_i = a; b_i = b; carry_i = cin; sub_i = sub; valid_i = 1'b1;
  endtask

  // Single transaction into an empty pipe; result must appear exactly 2 edges later
  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input res_t req);
    chk({nm, "_model"}, model(a, b, cin, sub), req);
    @(posedge clk); #1;
    ready_i = 1'b1;
    drive(a, b, cin, sub);
    chk({nm, "_ready"}, {35'd0, ready_o}, {35'd0, 1'b1});
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk({nm, "_lat1"}, {35'd0, valid_o}, {35'd0, 1'b0});
    @(posedge clk); #1;
    chk({nm, "_valid"}, {35'd0, valid_o}, {35'd0, 1'b1});
    chk({nm, "_res"}, dut_res(), req);
  endtask

  // Scoreboard: both transfers are decided at the coming rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_stable", {dut_res(), 3'b000, valid_o}, {held_r, 3'b000, 1'b1});
      end
      if (valid_i && ready_o) exp_q.push_back(model(a_i, b_i, carry_i, sub_i));
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {35'd0, valid_o}, 36'd0);
        end else begin
          chk("sb_result", dut_res(), exp_q.pop_front());
        end
      end
      hold_v = valid_o && !ready_i;
      held_r = dut_res();
    end
  end

  initial begin
    bit acc;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", dut_res(), '0);
    chk("reset_valid_ready", {34'd0, valid_o, ready_o}, {34'd0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;

    directed("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0});
    directed("sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("sub_7_5",   32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, '{32'h0000_0002, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0});
    directed("prop_c0",   32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    directed("prop_c1",   32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1});
    directed("sub_cin_x", 32'h0000_0009, 32'h0000_0003, 1'b1, 1'b1, '{32'h0000_0006, 1'b1, 1'b0, 1'b1, 1'b0});

    // Backpressure: two accepted while stalled, third waits for the first to leave
    @(posedge clk); #1;
    ready_i = 1'b0;
    drive(32'd10, 32'd20, 1'b0, 1'b0);
    chk("bp_ready0", {35'd0, ready_o}, {35'd0, 1'b1});
    @(posedge clk); #1;
    drive(32'd100, 32'd1, 1'b0, 1'b1);
    chk("bp_ready1", {35'd0, ready_o}, {35'd0, 1'b1});
    @(posedge clk); #1;
    drive(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    chk("bp_ready_low", {35'd0, ready_o}, {35'd0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_ready", {35'd0, ready_o}, {35'd0, 1'b0});
    chk("bp_hold_sum", {sum_o, 3'b000, valid_o}, {32'd30, 3'b000, 1'b1});
    ready_i = 1'b1;
    #1;
    chk("bp_ready_same_cycle", {35'd0, ready_o}, {35'd0, 1'b1});
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("bp_second", {sum_o, 3'b000, valid_o}, {32'd99, 3'b000, 1'b1});
    @(posedge clk); #1;
    chk("bp_third", {sum_o, carry_o, 2'b00, valid_o}, {32'd0, 1'b1, 2'b00, 1'b1});
    @(posedge clk); #1;
    chk("bp_empty", {35'd0, valid_o}, 36'd0);

    // Random valid/ready stress; operands only change once accepted
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!valid_i || acc) begin
        drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        valid_i = ($urandom_range(0, 3) != 0);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = valid_i && ready_o;
    end
    @(posedge clk); #1;
    valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 36'(exp_q.size()), 36'd0);

    // Async reset with both stages full
    @(posedge clk); #1;
    ready_i = 1'b0;
    drive(32'd1, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(32'd3, 32'd4, 1'b0, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("rst_full", {34'd0, valid_o, ready_o}, {34'd0, 1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", dut_res(), '0);
    chk("rst_async_vr", {34'd0, valid_o, ready_o}, {34'd0, 1'b0, 1'b1});
    @(posedge clk); #2;
    rst_n = 1'b1;
    ready_i = 1'b1;
    directed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, '{32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("final_empty", {35'd0, valid_o}, 36'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
Parametrised two-stage pipelined carry-lookahead adder/subtractor built from GROUP-bit lookahead groups.
- Exports word-level generate/propagate (G_o/P_o) so instances can be cascaded by an external lookahead unit.
- Valid/ready handshake on both sides with full-throughput backpressure.
- Used as the ALU adder datapath and as a standalone arithmetic unit.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of GROUP
GROUP, 4, bits per lookahead group; number of groups NG = WIDTH/GROUP

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
valid_i  input  1  input operands valid
ready_o  output  1  block can accept input this cycle
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
carry_i  input  1  carry-in; ignored when sub_i=1
sub_i  input  1  0: A+B+carry_i; 1: A-B (A+~B+1)
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
sum_o  output  WIDTH  result
carry_o  output  1  carry out of MSB; for subtract, 1 = no borrow (A>=B unsigned)
overflow_o  output  1  signed overflow: carry into MSB XOR carry out of MSB
G_o  output  1  word generate (carry out independent of effective carry-in)
P_o  output  1  word propagate (all bits propagate)

Behaviour:
- Reset:
  - Asynchronous assertion of rst_ni clears both stage valid flags and all data registers.
  - Outputs during reset: valid_o=0, sum_o=0, carry_o=0, overflow_o=0, G_o=0, P_o=0, ready_o=1.
  - Transactions in flight are discarded.
  - Normal operation resumes on the first clock edge after rst_ni deasserts.
- Effective operands: b_eff = b_i XOR {WIDTH{sub_i}}; cin_eff = sub_i ? 1 : carry_i.
- Stage 1 (register s1), captured when valid_i & ready_o:
  - per-bit g = a&b_eff, p = a^b_eff;
  - per-group GG[k], GP[k] via GROUP-bit lookahead;
  - cin_eff.
- Stage 2 (register s2):
  - group carries c[0]=cin_eff, c[k+1]=GG[k] | GP[k]&c[k], computed as a flattened lookahead;
  - intra-group bit carries, then sum = p ^ carries;
  - carry_o = c[NG]; overflow_o = carry into bit WIDTH-1 XOR carry_o;
  - G_o/P_o = word-level generate/propagate from the group terms, independent of cin_eff.
- Outputs are driven directly from s2 registers. Latency is exactly 2 cycles from the accepting edge to valid_o high, with no stalls.
- Handshake:
  - s2_en = !s2_valid | ready_i; s1_en = !s1_valid | s2_en; ready_o = s1_en (combinational).
  - s1_valid <= s1_en ? (valid_i & ready_o) : s1_valid.
  - s2_valid <= s2_en ? s1_valid : s2_valid.
  - Data registers load only on their enable.
  - A transfer occurs when valid & ready are both high. Throughput is 1 result per cycle while ready_i=1.
- Stall: with ready_i=0 the pipeline holds at most 2 transactions. Then ready_o=0; outputs stay stable until accepted.
- Simultaneous accept at input and output while full: both transfers occur in the same cycle, with no bubble.
- Results leave in input order. valid_o never drops without a handshake.
- Widths: all internal carries are 1 bit. No truncation other than carry_o holding the MSB carry.
- Elaboration fails if WIDTH % GROUP != 0 or GROUP < 1.

Decomposition:
- Package adder_pkg: gp_t struct {g,p}; function gp_combine(hi,lo) = {hi.g | hi.p&lo.g, hi.p&lo.p}.
- Sub-module cla_group (GROUP parameter):
  - inputs: a, b_eff slices, cin;
  - outputs: group G/P, per-bit sums, carry into MSB bit.
- cla_group is instantiated NG times in stage 2; its G/P logic is reused in stage 1.

Test Plan:
1. WIDTH=32, GROUP=4: a=0xFFFFFFFF, b=0x00000001, carry_i=0, sub=0 -> 2 cycles later valid_o=1, sum=0x00000000, carry_o=1, overflow_o=0, G_o=1, P_o=0.
2. a=0x7FFFFFFF, b=0x1, sub=0 -> sum=0x80000000, carry_o=0, overflow_o=1.
3. Subtract:
   - 5-7 -> sum=0xFFFFFFFE, carry_o=0, overflow_o=0.
   - 7-5 -> sum=0x2, carry_o=1.
   - 0x80000000-1 -> sum=0x7FFFFFFF, overflow_o=1.
4. a=0xAAAAAAAA, b=0x55555555:
   - carry_i=0 -> sum=0xFFFFFFFF, P_o=1, G_o=0, carry_o=0.
   - carry_i=1 -> sum=0x0, carry_o=1.
5. Backpressure: hold ready_i=0, present 3 back-to-back transactions -> first two accepted, ready_o=0 on the third; raise ready_i -> results in order, one per cycle, third accepted the same cycle the first leaves. Random valid/ready stress against a reference model: no loss, duplication or reordering.
6. Async reset: drop rst_ni mid-cycle with both stages full -> valid_o and all outputs 0 immediately, without waiting for a clock; after release, the first new input appears exactly 2 cycles after acceptance.
